// File: rtl/dzmmu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dzmmu_pkg
// Purpose  : Shared region addresses, DMA state encodings and address decode.
// Revision : 1.0
// ============================================================================
package dzmmu_pkg;

   localparam logic [15:0] c_ADDR_DMA     = 16'hFF46;
   localparam logic [15:0] c_ADDR_BOOT    = 16'hFF50;
   localparam logic [15:0] c_ADDR_HRAM_LO = 16'hFF80;
   localparam logic [15:0] c_ADDR_HRAM_HI = 16'hFFFE;
   localparam logic [15:0] c_ADDR_IE      = 16'hFFFF;

   localparam logic [1:0] c_ST_IDLE = 2'd0;
   localparam logic [1:0] c_ST_RD   = 2'd1;
   localparam logic [1:0] c_ST_WR   = 2'd2;

   typedef enum logic [2:0] {
      REGION_EXT,
      REGION_HRAM,
      REGION_IE,
      REGION_DMA,
      REGION_BOOT
   } region_e;

   // Priority order matters: HRAM first, then IE, DMA, BOOT, else external.
   function automatic region_e decodeRegion(input logic [15:0] addr);
      region_e region;
      if (addr >= c_ADDR_HRAM_LO && addr <= c_ADDR_HRAM_HI)
         region = REGION_HRAM;
      else if (addr == c_ADDR_IE)
         region = REGION_IE;
      else if (addr == c_ADDR_DMA)
         region = REGION_DMA;
      else if (addr == c_ADDR_BOOT)
         region = REGION_BOOT;
      else
         region = REGION_EXT;
      return region;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dzmmu_dma.sv
`default_nettype none
// ============================================================================
// Module   : dzmmu_dma
// Purpose  : OAM DMA engine; alternating read/write cycles over the external port.
// Revision : 1.0
// ============================================================================
module dzmmu_dma
   import dzmmu_pkg::*;
#(
   parameter int          DMA_LEN = 160,
   parameter logic [15:0] DMA_DST = 16'hFE00
) (
   input  logic        iClock,
   input  logic        iReset,
   input  logic        iStart,
   input  logic [7:0]  iSrc,
   input  logic [7:0]  iMemData,
   output logic        oBusy,
   output logic [15:0] oMemAddr,
   output logic [7:0]  oMemData,
   output logic        oMemWe
);

   localparam logic [7:0] c_LAST_IDX = 8'(DMA_LEN - 1);

   logic [1:0] r_state;
   logic [7:0] r_src;
   logic [7:0] r_idx;
   logic [7:0] r_byte;

   // A start request wins over the current state, so a rewrite restarts cleanly.
   always_ff @(posedge iClock) begin
      if (!iReset) begin
         r_state <= c_ST_IDLE;
         r_src   <= 8'h00;
         r_idx   <= 8'h00;
         r_byte  <= 8'h00;
      end else if (iStart) begin
         r_state <= c_ST_RD;
         r_src   <= iSrc;
         r_idx   <= 8'h00;
      end else begin
         case (r_state)
            c_ST_RD: begin
               r_byte  <= iMemData;
               r_state <= c_ST_WR;
            end
            c_ST_WR: begin
               if (r_idx == c_LAST_IDX) begin
                  r_state <= c_ST_IDLE;
               end else begin
                  r_idx   <= r_idx + 8'd1;
                  r_state <= c_ST_RD;
               end
            end
            c_ST_IDLE: r_state <= c_ST_IDLE;
            default:   r_state <= c_ST_IDLE;
         endcase
      end
   end

   // Reset suppresses a pending write within the very cycle it is asserted.
   always_comb begin
      oBusy    = (r_state != c_ST_IDLE);
      oMemData = r_byte;
      oMemWe   = (r_state == c_ST_WR) && iReset;
      if (r_state == c_ST_WR)
         oMemAddr = DMA_DST + {8'h00, r_idx};
      else
         oMemAddr = {r_src, 8'h00} + {8'h00, r_idx};
   end

endmodule
`default_nettype wire

// File: rtl/dzmmu.sv
`default_nettype none
// ============================================================================
// Module   : dzmmu
// Purpose  : Memory-side responder for the dzcpu bus: HRAM, IE, BOOT, OAM DMA.
// Revision : 1.0
// ============================================================================
module dzmmu
   import dzmmu_pkg::*;
#(
   parameter int          DMA_LEN = 160,
   parameter logic [15:0] DMA_DST = 16'hFE00
) (
   input  logic        iClock,
   input  logic        iReset,
   input  logic [15:0] iCpuAddr,
   input  logic [7:0]  iCpuData,
   input  logic        iCpuWe,
   output logic [7:0]  oCpuData,
   output logic [15:0] oMemAddr,
   output logic [7:0]  oMemData,
   output logic        oMemWe,
   input  logic [7:0]  iMemData,
   output logic        oBootRomEn,
   output logic [7:0]  oIntEnable,
   output logic        oDmaBusy
);

   region_e     w_region;
   logic        w_dmaStart;
   logic        w_dmaBusy;
   logic [15:0] w_dmaAddr;
   logic [7:0]  w_dmaData;
   logic        w_dmaWe;

   logic [7:0]  r_hram [0:126];
   logic [7:0]  r_intEnable;
   logic [7:0]  r_dmaReg;
   logic        r_bootRomEn;

   assign w_region   = decodeRegion(iCpuAddr);
   assign w_dmaStart = iCpuWe && (w_region == REGION_DMA);

   // HRAM keeps its contents across reset, so it has no reset branch.
   always_ff @(posedge iClock) begin
      if (iCpuWe && (w_region == REGION_HRAM))
         r_hram[iCpuAddr[6:0]] <= iCpuData;
   end

   always_ff @(posedge iClock) begin
      if (!iReset) begin
         r_intEnable <= 8'h00;
         r_dmaReg    <= 8'h00;
         r_bootRomEn <= 1'b1;
      end else if (iCpuWe) begin
         if (w_region == REGION_IE)
            r_intEnable <= iCpuData;
         if (w_region == REGION_DMA)
            r_dmaReg <= iCpuData;
         if ((w_region == REGION_BOOT) && (iCpuData != 8'h00))
            r_bootRomEn <= 1'b0;
      end
   end

   dzmmu_dma #(
      .DMA_LEN (DMA_LEN),
      .DMA_DST (DMA_DST)
   ) u_dma (
      .iClock   (iClock),
      .iReset   (iReset),
      .iStart   (w_dmaStart),
      .iSrc     (iCpuData),
      .iMemData (iMemData),
      .oBusy    (w_dmaBusy),
      .oMemAddr (w_dmaAddr),
      .oMemData (w_dmaData),
      .oMemWe   (w_dmaWe)
   );

   // The DMA engine owns the external port for the whole transfer.
   always_comb begin
      if (w_dmaBusy) begin
         oMemAddr = w_dmaAddr;
         oMemData = w_dmaData;
         oMemWe   = w_dmaWe;
      end else begin
         oMemAddr = iCpuAddr;
         oMemData = iCpuData;
         oMemWe   = iCpuWe && (w_region == REGION_EXT);
      end
   end

   always_comb begin
      case (w_region)
         REGION_HRAM: oCpuData = r_hram[iCpuAddr[6:0]];
         REGION_IE:   oCpuData = r_intEnable;
         REGION_DMA:  oCpuData = r_dmaReg;
         REGION_BOOT: oCpuData = {7'h7F, ~r_bootRomEn};
         default:     oCpuData = w_dmaBusy ? 8'hFF : iMemData;
      endcase
   end

   assign oBootRomEn = r_bootRomEn;
   assign oIntEnable = r_intEnable;
   assign oDmaBusy   = w_dmaBusy;

endmodule
`default_nettype wire

// File: tb/tb_dzmmu.sv
`default_nettype none
// ============================================================================
// Module   : tb_dzmmu
// Purpose  : Self-checking bench for dzmmu with an external memory model.
// Revision : 1.0
// ============================================================================
module tb_dzmmu;

   localparam int c_DMA_LEN = 160;

   logic        iClock = 1'b0;
   logic        iReset;
   logic [15:0] iCpuAddr;
   logic [7:0]  iCpuData;
   logic        iCpuWe;
   logic [7:0]  oCpuData;
   logic [15:0] oMemAddr;
   logic [7:0]  oMemData;
   logic        oMemWe;
   logic [7:0]  iMemData;
   logic        oBootRomEn;
   logic [7:0]  oIntEnable;
   logic        oDmaBusy;

   logic [7:0]  extMem [0:65535];
   logic        preWe = 1'b0;
   logic [15:0] preAddr = 16'h0000;
   logic [7:0]  preData = 8'h00;

   logic [23:0] expQ [$];
   int          checkCount = 0;
   int          errCount = 0;
   int          strayWrites = 0;

   always #5 iClock = ~iClock;

   dzmmu #(
      .DMA_LEN (c_DMA_LEN),
      .DMA_DST (16'hFE00)
   ) dut (
      .iClock     (iClock),
      .iReset     (iReset),
      .iCpuAddr   (iCpuAddr),
      .iCpuData   (iCpuData),
      .iCpuWe     (iCpuWe),
      .oCpuData   (oCpuData),
      .oMemAddr   (oMemAddr),
      .oMemData   (oMemData),
      .oMemWe     (oMemWe),
      .iMemData   (iMemData),
      .oBootRomEn (oBootRomEn),
      .oIntEnable (oIntEnable),
      .oDmaBusy   (oDmaBusy)
   );

   assign iMemData = extMem[oMemAddr];

   always @(posedge iClock) begin
      if (preWe)
         extMem[preAddr] <= preData;
      else if (oMemWe)
         extMem[oMemAddr] <= oMemData;
   end

   task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act !== exp) begin
         errCount++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Scoreboard: every OAM write is matched against the next queued expectation.
   always @(negedge iClock) begin
      if (oMemWe && oMemAddr >= 16'hFE00 && oMemAddr < 16'hFEA0) begin
         if (expQ.size() == 0)
            strayWrites++;
         else
            checkVal("dma_write", {8'h00, oMemAddr, oMemData}, {8'h00, expQ.pop_front()});
      end
   end

   task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic we);
      iCpuAddr = a;
      iCpuData = d;
      iCpuWe   = we;
   endtask

   task automatic step();
      @(posedge iClock);
      #1;
   endtask

   task automatic preload(input logic [15:0] base, input logic [7:0] pat);
      for (int i = 0; i < c_DMA_LEN; i++) begin
         preWe   = 1'b1;
         preAddr = base + 16'(i);
         preData = 8'(i) ^ pat;
         step();
      end
      preWe = 1'b0;
   endtask

   task automatic dmaStart(input logic [7:0] src, input logic [7:0] pat);
      drive(16'hFF46, src, 1'b1);
      @(posedge iClock);
      expQ.delete();
      for (int i = 0; i < c_DMA_LEN; i++)
         expQ.push_back({16'hFE00 + 16'(i), 8'(i) ^ pat});
      #1;
      drive(16'h0000, 8'h00, 1'b0);
   endtask

   // Counts busy cycles; mode 1 adds CPU traffic in the middle of the transfer.
   task automatic waitBusy(input int maxCycles, input int mode, output int n);
      n = 0;
      forever begin
         if (mode == 1 && n == 10) drive(16'hC000, 8'h00, 1'b0);
         if (mode == 1 && n == 11) drive(16'hC000, 8'h99, 1'b1);
         if (mode == 1 && n == 12) drive(16'hFF90, 8'h77, 1'b1);
         if (mode == 1 && n == 13) drive(16'hFF90, 8'h00, 1'b0);
         if (mode == 1 && n == 14) drive(16'hFF46, 8'h00, 1'b0);
         @(negedge iClock);
         if (!oDmaBusy) begin
            step();
            break;
         end
         if (mode == 1 && n == 10) checkVal("busy_ext_read", {24'h0, oCpuData}, 32'hFF);
         if (mode == 1 && n == 11) checkVal("busy_ext_we", {31'h0, oMemWe && oMemAddr == 16'hC000}, 32'h0);
         if (mode == 1 && n == 13) checkVal("busy_hram_read", {24'h0, oCpuData}, 32'h77);
         if (mode == 1 && n == 14) checkVal("busy_dmareg_read", {24'h0, oCpuData}, 32'hC0);
         n++;
         step();
         drive(16'h0000, 8'h00, 1'b0);
         if (n >= maxCycles) break;
      end
   endtask

   task automatic checkOam(input string tag, input int splitIdx, input logic [7:0] patLo,
                           input logic [7:0] patHi);
      int bad;
      bad = 0;
      for (int i = 0; i < c_DMA_LEN; i++)
         if (extMem[16'hFE00 + 16'(i)] !== (8'(i) ^ ((i < splitIdx) ? patLo : patHi)))
            bad++;
      checkVal(tag, bad, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
      $fatal(1);
   end

   initial begin
      int n;
      iReset = 1'b0;
      drive(16'h0000, 8'h00, 1'b0);
      step();
      preload(16'hC000, 8'h3C);
      preload(16'hD000, 8'hA7);
      iReset = 1'b1;

      @(negedge iClock);
      checkVal("rst_boot_en", {31'h0, oBootRomEn}, 32'h1);
      checkVal("rst_ie", {24'h0, oIntEnable}, 32'h0);
      checkVal("rst_busy", {31'h0, oDmaBusy}, 32'h0);
      step();
      drive(16'hFFFF, 8'h00, 1'b0); @(negedge iClock);
      checkVal("rst_read_ie", {24'h0, oCpuData}, 32'h00); step();
      drive(16'hFF50, 8'h00, 1'b0); @(negedge iClock);
      checkVal("rst_read_boot", {24'h0, oCpuData}, 32'hFE); step();
      drive(16'hFF46, 8'h00, 1'b0); @(negedge iClock);
      checkVal("rst_read_dmareg", {24'h0, oCpuData}, 32'h00); step();

      drive(16'hFF80, 8'h5A, 1'b1); @(negedge iClock);
      checkVal("hram_lo_no_we", {31'h0, oMemWe}, 32'h0); step();
      drive(16'hFFFE, 8'hA5, 1'b1); @(negedge iClock);
      checkVal("hram_hi_no_we", {31'h0, oMemWe}, 32'h0); step();
      drive(16'hFF80, 8'h00, 1'b0); @(negedge iClock);
      checkVal("hram_lo_read", {24'h0, oCpuData}, 32'h5A); step();
      drive(16'hFFFE, 8'h00, 1'b0); @(negedge iClock);
      checkVal("hram_hi_read", {24'h0, oCpuData}, 32'hA5); step();

      drive(16'hFFFF, 8'h1F, 1'b1); step();
      drive(16'hFFFF, 8'h00, 1'b0); @(negedge iClock);
      checkVal("ie_out", {24'h0, oIntEnable}, 32'h1F);
      checkVal("ie_read", {24'h0, oCpuData}, 32'h1F); step();

      drive(16'hC123, 8'h4D, 1'b1); @(negedge iClock);
      checkVal("ext_wr_port", {7'h0, oMemWe, oMemAddr, oMemData}, {7'h0, 1'b1, 16'hC123, 8'h4D});
      step();
      drive(16'hC123, 8'h00, 1'b0); @(negedge iClock);
      checkVal("ext_read", {24'h0, oCpuData}, 32'h4D); step();

      drive(16'hFF50, 8'h00, 1'b1); step();
      drive(16'h0000, 8'h00, 1'b0); @(negedge iClock);
      checkVal("boot_zero_write", {31'h0, oBootRomEn}, 32'h1); step();
      drive(16'hFF50, 8'h01, 1'b1); step();
      drive(16'hFF50, 8'h00, 1'b0); @(negedge iClock);
      checkVal("boot_clear", {31'h0, oBootRomEn}, 32'h0);
      checkVal("boot_read", {24'h0, oCpuData}, 32'hFF); step();
      drive(16'hFF50, 8'h00, 1'b1); step();
      drive(16'h0000, 8'h00, 1'b0); @(negedge iClock);
      checkVal("boot_sticky", {31'h0, oBootRomEn}, 32'h0); step();

      dmaStart(8'hC0, 8'h3C);
      waitBusy(400, 1, n);
      checkVal("full_busy_cycles", n, 320);
      checkVal("full_queue_left", expQ.size(), 0);
      checkOam("full_oam", c_DMA_LEN, 8'h3C, 8'h3C);
      checkVal("full_cpu_write_dropped", {24'h0, extMem[16'hC000]}, 32'h3C);

      dmaStart(8'hC0, 8'h3C);
      waitBusy(50, 0, n);
      checkVal("restart_first_run", n, 50);
      dmaStart(8'hD0, 8'hA7);
      waitBusy(400, 0, n);
      checkVal("restart_busy_cycles", n, 320);
      checkVal("restart_queue_left", expQ.size(), 0);
      checkOam("restart_oam", c_DMA_LEN, 8'hA7, 8'hA7);

      dmaStart(8'hC0, 8'h3C);
      waitBusy(100, 0, n);
      iReset = 1'b0;
      @(negedge iClock);
      checkVal("rstmid_we_during", {31'h0, oMemWe}, 32'h0);
      step();
      iReset = 1'b1;
      expQ.delete();
      @(negedge iClock);
      checkVal("rstmid_busy", {31'h0, oDmaBusy}, 32'h0);
      checkVal("rstmid_we", {31'h0, oMemWe}, 32'h0);
      checkVal("rstmid_boot_en", {31'h0, oBootRomEn}, 32'h1);
      checkVal("rstmid_ie", {24'h0, oIntEnable}, 32'h0);
      for (int i = 0; i < 30; i++) step();
      checkOam("rstmid_partial_oam", 50, 8'h3C, 8'hA7);
      checkVal("stray_oam_writes", strayWrites, 0);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dzmmu.md
# dzmmu

Memory-side responder for the dzcpu MCU bus. It services the CPU's address, data and write-enable requests, and holds the small on-die resources: HRAM (FF80–FFFE), the interrupt-enable register (FFFF), the boot-ROM disable latch (FF50) and the OAM DMA engine (FF46). All other addresses pass through to the shared external memory port (cartridge ROM, VRAM, WRAM, OAM). While a DMA transfer runs, the engine owns that external port.

## Interface
Parameters:
- DMA_LEN, 160 — bytes per OAM DMA transfer.
- DMA_DST, 16'hFE00 — OAM base address, the DMA destination.

Ports:
- iClock  in  1  — single clock; everything is posedge.
- iReset  in  1  — synchronous, active-low reset.
- iCpuAddr  in  16  — CPU bus address (oMCUAddr of dzcpu).
- iCpuData  in  8  — CPU write data.
- iCpuWe  in  1  — CPU write enable.
- oCpuData  out  8  — read data to the CPU (iMCUData of dzcpu); combinational.
- oMemAddr  out  16  — external memory address.
- oMemData  out  8  — external write data.
- oMemWe  out  1  — external write enable.
- iMemData  in  8  — external read data; combinational from oMemAddr.
- oBootRomEn  out  1  — 1 selects the boot ROM for 0000–00FF.
- oIntEnable  out  8  — IE register contents.
- oDmaBusy  out  1  — DMA transfer in progress.

## Operation
- Decode regions, in priority order: HRAM FF80–FFFE; IE FFFF; DMA reg FF46; BOOT reg FF50; everything else is EXT.
- HRAM is a 127×8 array.
  - Read is combinational.
  - A write lands at the posedge when iCpuWe=1.
  - Contents are not cleared by reset.
- IE: read/write, reset value 8'h00.
- BOOT:
  - Any write of a nonzero value clears oBootRomEn (reset value 1).
  - The clear is sticky until reset.
  - A zero write has no effect.
  - Read returns {7'h7F, ~oBootRomEn}.
- DMA reg: read returns the last written value (reset 8'h00). A write starts a transfer.
- EXT access, DMA idle:
  - oMemAddr=iCpuAddr, oMemData=iCpuData, oMemWe=iCpuWe, oCpuData=iMemData.
- EXT access, DMA busy:
  - CPU reads return 8'hFF.
  - CPU writes are dropped.
  - The external port is driven by DMA.
- HRAM, IE, BOOT and FF46 stay fully accessible during DMA.
- The DMA FSM has three states: IDLE, RD, WR.
  - IDLE → RD on a CPU write to FF46. This latches src=iCpuData and sets idx=0.
  - RD: oMemAddr={src,8'h00}+idx, oMemWe=0. iMemData is latched into a byte register. Next state is WR.
  - WR: oMemAddr=DMA_DST+idx, oMemData=latched byte, oMemWe=1.
  - From WR, if idx==DMA_LEN-1, go to IDLE; otherwise increment idx and go to RD.
  - idx is 8 bits wide. DMA_LEN ≤ 256; there is no wrap beyond DMA_LEN-1.
- A write to FF46 while busy restarts the transfer: new src, idx=0, state RD on the next cycle. The in-flight byte is abandoned. A WR cycle coinciding with the restart write still completes its write.
- oDmaBusy = (state != IDLE).
- When idle and the CPU is not writing, oMemWe = 0 (EXT path only).

## Timing
- Reset values: oBootRomEn=1, oIntEnable=0, oDmaBusy=0, DMA state IDLE.
  - oMemWe follows iCpuWe for EXT addresses and is 0 for internal addresses.
  - oMemAddr and oCpuData are combinational.
- CPU reads are zero-latency: oCpuData is valid in the same cycle as iCpuAddr.
- CPU writes take effect at the posedge of the cycle where iCpuWe=1.
- DMA start: FF46 is written at edge N.
  - oDmaBusy is 1 during cycles N+1 … N+2·DMA_LEN.
  - The first RD is cycle N+1; the first WR is cycle N+2.
  - The last WR is cycle N+2·DMA_LEN. oDmaBusy falls after that edge.
  - Total: 320 cycles at the default DMA_LEN.
- Reset asserted mid-DMA: the FSM goes to IDLE at that edge and oMemWe drops to 0 in the same cycle. Partial OAM contents remain.
- A CPU EXT write during a DMA WR cycle is dropped, never merged.

## Structure
- Shared definitions belong in aDefinitions.v: region address constants (FF46, FF50, FF80, FFFE, FFFF) and the DMA state encodings.
- One sub-module, dzmmu_dma: the FSM, idx counter, byte latch and port-ownership mux select.
- The top level holds the decode, HRAM, the IE/BOOT/DMA registers and the read-data mux.

## Test plan
- Reset check: after reset, oBootRomEn=1, oIntEnable=0, oDmaBusy=0. Read FFFF → 8'h00; read FF50 → 8'hFE.
- HRAM: write FF80=8'h5A and FFFE=8'hA5; read both back same cycle → 5A / A5. No external oMemWe pulse occurs.
- BOOT: write FF50=8'h00 → oBootRomEn stays 1. Write FF50=8'h01 → 0 at next cycle. Write FF50=8'h00 → remains 0.
- DMA full: preload external C000–C09F with i^8'h3C, then write FF46=8'hC0.
  - oDmaBusy is high for exactly 320 cycles.
  - OAM FE00–FE9F receives i^8'h3C in order.
  - A CPU read of C000 mid-transfer → 8'hFF. An HRAM read/write mid-transfer works.
- DMA restart: write FF46=8'hC0, wait 50 cycles, write FF46=8'hD0.
  - oDmaBusy stays high for 320 cycles after the second write.
  - The final FE00–FE9F contents come from D000–D09F.
- Reset mid-DMA: assert iReset=0 at cycle 100 of a transfer. oMemWe=0 and oDmaBusy=0 after that edge, and no further OAM writes occur.
